lsu_dmem_ctrl: RTL and testbench
================================

Name: lsu_dmem_ctrl

Overview:
- Load/store controller on the initiator side of the 16-bit data memory.
- Accepts one 32-bit-datapath load/store request at a time from the core: byte, halfword or word, signed or unsigned.
- Drives the memory's active-low write-enable and active-low byte-enables, one halfword per beat.
- Splits word accesses into two beats, assembles and extends load data, and returns a single response per request.

Parameters:
- ADDRESS_WIDTH, 12, memory halfword-index width; byte address is ADDRESS_WIDTH+1 bits.
- BYTE_WIDTH, 8, bits per byte lane.
- BYTES, 2, lanes per memory word; this block supports only 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  ADDRESS_WIDTH+1  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  one-cycle response pulse; no backpressure.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  misaligned or illegal request; valid with rsp_valid.
- mem_addr  output  ADDRESS_WIDTH  halfword index.
- mem_we_n  output  1  active-low write enable.
- mem_be_n  output  2  active-low lane enables; bit0 = bits 7:0, bit1 = bits 15:8.
- mem_wdata  output  16  write data.
- mem_rdata  input  16  combinational read data for mem_addr.

Behaviour:
- FSM states: IDLE, BEAT0, BEAT1, RESP. Reset state is IDLE.
- Reset values: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we_n=1, mem_be_n=2'b11, mem_addr=0, mem_wdata=0.
- Reset is asynchronous. Asserting it mid-operation forces IDLE and deasserts mem_we_n in the same instant, so no partial beat completes. A word store interrupted between beats leaves only the low half written.
- req_ready=1 only in IDLE. A request is accepted when req_valid & req_ready; all request fields are registered at acceptance.
- Error check at acceptance: size 11, half with addr[0]=1, or word with addr[1:0]!=0.
  - An erroring request goes IDLE -> RESP with rsp_err=1, rsp_rdata=0.
  - No memory beat is issued (mem_we_n stays 1, mem_be_n stays 11).
- Legal byte/half request: IDLE -> BEAT0 -> RESP.
- Legal word request: IDLE -> BEAT0 -> BEAT1 -> RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. The next request can be accepted the cycle after RESP.
- Latency from the acceptance edge to the rsp_valid cycle: error 1, byte/half 2, word 3.
- Beat addressing: BEAT0 mem_addr = addr[ADDRESS_WIDTH:1]; BEAT1 mem_addr = BEAT0 index + 1. A word is aligned to an even index, so no index wrap can occur.
- Memory outputs outside BEAT0/BEAT1: mem_we_n=1, mem_be_n=11; mem_addr and mem_wdata hold their last value.
- Store beats (mem_we_n=0):
  - Byte: mem_be_n = addr[0] ? 01 : 10; mem_wdata = {wdata[7:0], wdata[7:0]}.
  - Half: mem_be_n=00; mem_wdata = wdata[15:0].
  - Word: BEAT0 writes wdata[15:0], BEAT1 writes wdata[31:16], both with mem_be_n=00 (little-endian).
- Load beats: mem_we_n=1, mem_be_n=00. mem_rdata is captured at the end of each beat cycle.
  - Byte: lane selected by addr[0].
  - Byte/half: sign- or zero-extended per req_unsigned.
  - Word: rsp_rdata = {BEAT1 data, BEAT0 data}; req_unsigned is ignored.
- Store response: rsp_rdata=0, rsp_err=0.
- rsp_rdata and rsp_err are registered and held until the next RESP. They are valid only when rsp_valid=1.
- req_valid arriving while busy is ignored until req_ready=1; the requester must hold it.

Test Plan:
- Reset, then store byte 0xA5 to addr 0x003 -> BEAT0 shows mem_addr=1, mem_be_n=01, mem_wdata=0xA5A5, mem_we_n=0. rsp_valid fires 2 cycles after acceptance, rsp_err=0.
- Store word 0xDEADBEEF at 0x010, then load word 0x010 -> store beats write 0xBEEF at idx 8 and 0xDEAD at idx 9; load returns 0xDEADBEEF, 3 cycles after acceptance.
- Memory idx 4 = 0x80F0: load byte signed 0x009 -> 0xFFFFFF80; load byte unsigned 0x009 -> 0x00000080; load half signed 0x008 -> 0xFFFF80F0.
- Load half 0x005, word 0x006, and size 11 -> each gives rsp_err=1, rsp_rdata=0, 1-cycle latency, with no mem_we_n or mem_be_n activity.
- Assert rst_n low during BEAT1 of a word store of 0x12345678 to 0x020 -> mem_we_n=1 immediately; idx 16 = 0x5678, idx 17 unchanged; no rsp_valid; req_ready=1 after release.
- Hold req_valid high across back-to-back requests -> exactly one acceptance per IDLE visit; rsp_valid never high on two consecutive cycles.

Source files
------------

// File: rtl/lsu_dmem_ctrl.sv
// Load/store controller for a 16-bit data memory: one 32-bit request at a time,
// split into halfword beats with active-low enables, single registered response.
module lsu_dmem_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned BYTE_WIDTH    = 8,
  parameter int unsigned BYTES         = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [1:0]                    req_size,
  input  logic                          req_unsigned,
  input  logic [ADDRESS_WIDTH:0]        req_addr,
  input  logic [31:0]                   req_wdata,
  output logic                          rsp_valid,
  output logic [31:0]                   rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDRESS_WIDTH-1:0]      mem_addr,
  output logic                          mem_we_n,
  output logic [BYTES-1:0]              mem_be_n,
  output logic [BYTES*BYTE_WIDTH-1:0]   mem_wdata,
  input  logic [BYTES*BYTE_WIDTH-1:0]   mem_rdata
);

  localparam int unsigned HW = BYTES * BYTE_WIDTH;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  state_t state;

  logic                  r_we;
  logic                  r_uns;
  logic                  r_lane;
  logic [1:0]            r_size;
  logic [HW-1:0]         r_wdata_hi;
  logic [HW-1:0]         r_lo;

  logic                  req_err;
  logic [HW-1:0]         st_data;
  logic [BYTES-1:0]      st_be;
  logic [BYTE_WIDTH-1:0] ld_byte;
  logic [31:0]           ld_ext;

  always_comb begin
    req_err = (req_size == 2'b11)
            | ((req_size == 2'b01) & req_addr[0])
            | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
    st_data = req_wdata[HW-1:0];
    st_be   = '0;
    if (req_size == 2'b00) begin
      st_data = {BYTES{req_wdata[BYTE_WIDTH-1:0]}};
      st_be   = req_addr[0] ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    ld_byte = r_lane ? mem_rdata[2*BYTE_WIDTH-1:BYTE_WIDTH] : mem_rdata[BYTE_WIDTH-1:0];
    if (r_size == 2'b00)
      ld_ext = r_uns ? {{(32-BYTE_WIDTH){1'b0}}, ld_byte}
                     : {{(32-BYTE_WIDTH){ld_byte[BYTE_WIDTH-1]}}, ld_byte};
    else
      ld_ext = r_uns ? {{(32-HW){1'b0}}, mem_rdata}
                     : {{(32-HW){mem_rdata[HW-1]}}, mem_rdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      mem_addr   <= '0;
      mem_we_n   <= 1'b1;
      mem_be_n   <= '1;
      mem_wdata  <= '0;
      r_we       <= 1'b0;
      r_uns      <= 1'b0;
      r_lane     <= 1'b0;
      r_size     <= '0;
      r_wdata_hi <= '0;
      r_lo       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            r_we       <= req_we;
            r_uns      <= req_unsigned;
            r_lane     <= req_addr[0];
            r_size     <= req_size;
            r_wdata_hi <= req_wdata[31:HW];
            if (req_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              // Beat-0 bus values are set up at acceptance so they are registered outputs.
              state    <= BEAT0;
              mem_addr <= req_addr[ADDRESS_WIDTH:1];
              mem_we_n <= ~req_we;
              mem_be_n <= req_we ? st_be : '0;
              if (req_we)
                mem_wdata <= st_data;
            end
          end
        end
        BEAT0: begin
          if (r_size == 2'b10) begin
            state    <= BEAT1;
            mem_addr <= mem_addr + ADDRESS_WIDTH'(1);
            r_lo     <= mem_rdata;
            if (r_we)
              mem_wdata <= r_wdata_hi;
          end else begin
            state     <= RESP;
            mem_we_n  <= 1'b1;
            mem_be_n  <= '1;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= r_we ? '0 : ld_ext;
          end
        end
        BEAT1: begin
          state     <= RESP;
          mem_we_n  <= 1'b1;
          mem_be_n  <= '1;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= r_we ? '0 : {mem_rdata, r_lo};
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Bench for lsu_dmem_ctrl: byte-array reference memory predicts responses,
// bus beats and final memory contents for directed and random requests.
module tb_lsu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [12:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [11:0] mem_addr;
  logic        mem_we_n;
  logic [1:0]  mem_be_n;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  lsu_dmem_ctrl #(.ADDRESS_WIDTH(12), .BYTE_WIDTH(8), .BYTES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we_n(mem_we_n), .mem_be_n(mem_be_n),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Physical memory seen by the DUT; pokes come from the bench only while idle.
  logic [15:0] dmem [0:4095];
  logic        poke_en = 1'b0;
  logic [11:0] poke_a = '0;
  logic [15:0] poke_d = '0;

  assign mem_rdata = dmem[mem_addr];

  always @(posedge clk) begin
    if (poke_en)
      dmem[poke_a] <= poke_d;
    else if (!mem_we_n) begin
      if (!mem_be_n[0]) dmem[mem_addr][7:0]  <= mem_wdata[7:0];
      if (!mem_be_n[1]) dmem[mem_addr][15:8] <= mem_wdata[15:8];
    end
  end

  // Reference model: plain byte-addressed memory.
  logic [7:0] rmem [0:8191];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [11:0] idx, input logic [15:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_a = idx; poke_d = d;
    rmem[{idx, 1'b0}] = d[7:0];
    rmem[{idx, 1'b1}] = d[15:8];
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [12:0] a, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic er,
                      output int nbeats, output int nwr,
                      output logic [11:0] b0a, output logic [1:0] b0be,
                      output logic [15:0] b0wd, output logic [11:0] b1a,
                      output logic [15:0] b1wd);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nbeats = 0; nwr = 0;
    b0a = '0; b0be = '1; b0wd = '0; b1a = '0; b1wd = '0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
      if (mem_be_n != 2'b11 || !mem_we_n) begin
        if (nbeats == 0) begin
          b0a = mem_addr; b0be = mem_be_n; b0wd = mem_wdata;
        end else begin
          b1a = mem_addr; b1wd = mem_wdata;
        end
        nbeats++;
        if (!mem_we_n) nwr++;
      end
    end
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk);
    check("rsp_pulse", {31'b0, rsp_valid}, 32'd0);
  endtask

  // Predict from the reference memory, run the request, compare, then update the model.
  task automatic run(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [12:0] a, input logic [31:0] wd);
    int lat, nb, nw, elat, enb;
    logic [31:0] rd, e;
    logic er, eer;
    logic [11:0] b0a, b1a;
    logic [1:0] b0be, ebe;
    logic [15:0] b0wd, b1wd, hw;
    logic [7:0] by;
    eer = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    elat = eer ? 1 : (sz == 2'd2 ? 3 : 2);
    enb = eer ? 0 : (sz == 2'd2 ? 2 : 1);
    by = rmem[a];
    hw = {rmem[a + 13'd1], rmem[a]};
    e = 32'd0;
    if (!eer && !we) begin
      case (sz)
        2'd0: e = uns ? {24'd0, by} : {{24{by[7]}}, by};
        2'd1: e = uns ? {16'd0, hw} : {{16{hw[15]}}, hw};
        default: e = {rmem[a + 13'd3], rmem[a + 13'd2], hw};
      endcase
    end
    xact(we, sz, uns, a, wd, lat, rd, er, nb, nw, b0a, b0be, b0wd, b1a, b1wd);
    check("latency", lat, elat);
    check("rsp_err", {31'b0, er}, {31'b0, eer});
    check("rsp_rdata", rd, e);
    check("beats", nb, enb);
    check("wr_beats", nw, (we && !eer) ? enb : 0);
    if (!eer) begin
      ebe = (we && sz == 2'd0) ? (a[0] ? 2'b01 : 2'b10) : 2'b00;
      check("b0_addr", {20'd0, b0a}, {20'd0, a[12:1]});
      check("b0_be_n", {30'd0, b0be}, {30'd0, ebe});
      if (we) begin
        check("b0_wdata", {16'd0, b0wd}, sz == 2'd0 ? {16'd0, wd[7:0], wd[7:0]} : {16'd0, wd[15:0]});
        if (sz == 2'd2) begin
          check("b1_addr", {20'd0, b1a}, {20'd0, a[12:1]} + 32'd1);
          check("b1_wdata", {16'd0, b1wd}, {16'd0, wd[31:16]});
        end
      end
    end
    if (we && !eer) begin
      rmem[a] = wd[7:0];
      if (sz != 2'd0) rmem[a + 13'd1] = wd[15:8];
      if (sz == 2'd2) begin
        rmem[a + 13'd2] = wd[23:16];
        rmem[a + 13'd3] = wd[31:24];
      end
    end
  endtask

  initial begin
    int acc, nrsp, dbl, nrst;
    logic prev;
    logic [15:0] keep17;
    logic [1:0] sz;
    logic [12:0] a;

    for (int i = 0; i < 8192; i++) rmem[i] = 8'h00;
    for (int i = 0; i < 64; i++) poke(12'(i), 16'($urandom));

    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_we_n", {31'b0, mem_we_n}, 32'd1);
    check("rst_be_n", {30'b0, mem_be_n}, 32'd3);
    check("rst_addr", {20'b0, mem_addr}, 32'd0);
    check("rst_wdata", {16'b0, mem_wdata}, 32'd0);
    rst_n = 1'b1;

    run(1'b1, 2'd0, 1'b0, 13'h003, 32'h000000A5);
    run(1'b1, 2'd2, 1'b0, 13'h010, 32'hDEADBEEF);
    run(1'b0, 2'd2, 1'b0, 13'h010, 32'h0);
    check("word_lo_mem", {16'd0, dmem[8]}, 32'h0000BEEF);
    check("word_hi_mem", {16'd0, dmem[9]}, 32'h0000DEAD);

    poke(12'd4, 16'h80F0);
    run(1'b0, 2'd0, 1'b0, 13'h009, 32'h0);
    run(1'b0, 2'd0, 1'b1, 13'h009, 32'h0);
    run(1'b0, 2'd1, 1'b0, 13'h008, 32'h0);
    run(1'b0, 2'd1, 1'b1, 13'h008, 32'h0);
    run(1'b0, 2'd0, 1'b0, 13'h008, 32'h0);

    run(1'b0, 2'd1, 1'b0, 13'h005, 32'h0);
    run(1'b0, 2'd2, 1'b0, 13'h006, 32'h0);
    run(1'b0, 2'd3, 1'b0, 13'h000, 32'h0);
    run(1'b1, 2'd2, 1'b0, 13'h012, 32'h11223344);

    // Reset during the second beat of a word store.
    keep17 = {rmem[13'd35], rmem[13'd34]};
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 13'h020; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 check("b1_store_we_n", {31'b0, mem_we_n}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_we_n", {31'b0, mem_we_n}, 32'd1);
    check("arst_be_n", {30'b0, mem_be_n}, 32'd3);
    nrst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) nrst++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (rsp_valid) nrst++;
    end
    check("arst_no_rsp", nrst, 0);
    check("arst_ready", {31'b0, req_ready}, 32'd1);
    check("arst_lo_mem", {16'd0, dmem[16]}, 32'h00005678);
    check("arst_hi_mem", {16'd0, dmem[17]}, {16'd0, keep17});
    rmem[13'd32] = 8'h78;
    rmem[13'd33] = 8'h56;

    // Held request: one acceptance per IDLE visit.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd1; req_unsigned = 1'b1; req_addr = 13'h008;
    acc = 0; nrsp = 0; dbl = 0; prev = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (req_valid && req_ready) acc++;
      if (rsp_valid) begin
        nrsp++;
        if (prev) dbl++;
      end
      prev = rsp_valid;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_accepts", acc, 10);
    check("b2b_responses", nrsp, 10);
    check("b2b_double_pulse", dbl, 0);

    for (int n = 0; n < 300; n++) begin
      sz = 2'($urandom_range(0, 3));
      a = 13'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      run(1'($urandom), sz, 1'($urandom), a, $urandom);
    end

    for (int i = 0; i < 64; i++)
      check("final_mem", {16'd0, dmem[i]}, {16'd0, rmem[2*i+1], rmem[2*i]});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
